// File: rtl/arb4x32_pkg.sv
// Shared types, constants and the round-robin pick helper for the 4x32 bus arbiter.
package arb4x32_pkg;

  localparam int NREQ = 4;
  localparam int DW   = 32;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  // Returns the first set request bit scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
  function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux4x32.sv
// Plain 4:1 data mux, 32 bits wide, steered by the arbiter's registered select.
module mux4x32
  import arb4x32_pkg::*;
(
  input  logic [1:0]    sel_i,
  input  logic [DW-1:0] d0_i,
  input  logic [DW-1:0] d1_i,
  input  logic [DW-1:0] d2_i,
  input  logic [DW-1:0] d3_i,
  output logic [DW-1:0] y_o
);

  always_comb begin
    y_o = d0_i;
    unique case (sel_i)
      2'd0: y_o = d0_i;
      2'd1: y_o = d1_i;
      2'd2: y_o = d2_i;
      2'd3: y_o = d3_i;
      default: y_o = d0_i;
    endcase
  end

endmodule

// File: rtl/bus_arb4x32.sv
// Four-requester round-robin bus arbiter with hold timeout and withdrawal abort.
// Optional grant locking across handshakes is enabled by defining ARB4X32_LOCK_EN.
module bus_arb4x32
  import arb4x32_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [DW-1:0]   a0,
  input  logic [DW-1:0]   a1,
  input  logic [DW-1:0]   a2,
  input  logic [DW-1:0]   a3,
  input  logic            y_ready,
`ifdef ARB4X32_LOCK_EN
  input  logic [NREQ-1:0] lock,
`endif
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      s,
  output logic [DW-1:0]   y,
  output logic            y_valid,
  output logic [NREQ-1:0] ack,
  output logic            timeout
);

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);
  localparam logic       HOLD_EN    = (MAX_HOLD != 0);

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      s_q, s_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  logic            handshake;
  logic            lock_hit;
  logic [1:0]      pick;

  assign y_valid   = (state_q == XFER);
  assign handshake = y_valid & y_ready;
  assign pick      = rr_pick(req, ptr_q);

`ifdef ARB4X32_LOCK_EN
  assign lock_hit = lock[s_q];
`else
  assign lock_hit = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    s_d       = s_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|req) begin
          s_d     = pick;
          gnt_d   = 4'b0001 << pick;
          state_d = XFER;
        end else begin
          gnt_d = '0;
        end
      end
      XFER: begin
        if (handshake) begin
          // A locked owner keeps the bus back-to-back; ptr only moves on release.
          cnt_d = '0;
          if (!lock_hit) begin
            ptr_d   = s_q;
            gnt_d   = '0;
            state_d = IDLE;
          end
        end else if (!req[s_q]) begin
          gnt_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (HOLD_EN && (cnt_q == HOLD_LIMIT)) begin
          timeout_d = 1'b1;
          ptr_d     = s_q;
          gnt_d     = '0;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        gnt_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd3;
      s_q       <= 2'd0;
      gnt_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      s_q       <= s_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign s       = s_q;
  assign ack     = {NREQ{handshake}} & gnt_q;
  assign timeout = timeout_q;

  mux4x32 u_mux (
    .sel_i (s_q),
    .d0_i  (a0),
    .d1_i  (a1),
    .d2_i  (a2),
    .d3_i  (a3),
    .y_o   (y)
  );

endmodule

// File: tb/tb_bus_arb4x32.sv
// Scoreboard bench for bus_arb4x32: a transaction-level model predicts each cycle's
// bus activity, a negedge monitor compares. Directed scenarios then random traffic.
module tb_bus_arb4x32;

  localparam int MAXH = 15;
`ifdef ARB4X32_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] a_drv [4];
  logic        y_ready;
  logic [3:0]  lock_drv;
  logic [3:0]  gnt;
  logic [1:0]  s;
  logic [31:0] y;
  logic        y_valid;
  logic [3:0]  ack;
  logic        timeout;

  always #5 clk = ~clk;

  bus_arb4x32 #(.MAX_HOLD(MAXH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .a0      (a_drv[0]),
    .a1      (a_drv[1]),
    .a2      (a_drv[2]),
    .a3      (a_drv[3]),
    .y_ready (y_ready),
`ifdef ARB4X32_LOCK_EN
    .lock    (lock_drv),
`endif
    .gnt     (gnt),
    .s       (s),
    .y       (y),
    .y_valid (y_valid),
    .ack     (ack),
    .timeout (timeout)
  );

  typedef struct packed {
    logic        valid;
    logic        to;
    logic [3:0]  gnt;
    logic [1:0]  s;
    logic [3:0]  ack;
    logic [31:0] y;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int errors = 0;
  int checks = 0;
  int to_seen = 0;
  bit run_mon = 1'b0;

  // Reference model: who owns the bus, who was served last, when ownership began.
  int          owner;
  int          last;
  int          entry;
  int          edge_n;
  logic [31:0] held_data;
  logic        to_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner  = -1;
    last   = 3;
    entry  = 0;
    to_exp = 1'b0;
  endtask

  // Apply the bus rules to the inputs that were present at the edge just taken.
  task automatic model_edge();
    bit found;
    edge_n++;
    to_exp = 1'b0;
    if (owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        int i = (last + k) % 4;
        if (!found && req[i]) begin
          found     = 1'b1;
          owner     = i;
          entry     = edge_n;
          held_data = a_drv[i];
        end
      end
    end else if (y_ready) begin
      if (LOCK_EN && lock_drv[owner]) entry = edge_n;
      else begin
        last  = owner;
        owner = -1;
      end
    end else if (!req[owner]) begin
      owner = -1;
    end else if (MAXH != 0 && (edge_n - entry) == MAXH + 1) begin
      to_exp = 1'b1;
      last   = owner;
      owner  = -1;
    end
  endtask

  task automatic expect_cycle();
    exp_t e;
    if (owner >= 0 || to_exp) begin
      e.valid = (owner >= 0);
      e.to    = to_exp;
      e.gnt   = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
      e.s     = (owner >= 0) ? 2'(owner) : 2'd0;
      e.ack   = (owner >= 0 && y_ready) ? e.gnt : 4'b0000;
      e.y     = held_data;
      sb.push_back(e);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic rdy, input logic [3:0] lk);
    @(posedge clk);
    #1;
    model_edge();
    req      = r;
    y_ready  = rdy;
    lock_drv = lk;
    for (int i = 0; i < 4; i++)
      if (!r[i] && owner != i) a_drv[i] = $urandom;
    expect_cycle();
  endtask

  // Asynchronous reset mid-cycle: outputs must drop before any clock edge.
  task automatic do_reset();
    #1;
    rst = 1'b1;
    sb.delete();
    #1;
    check("rst_gnt", 64'(gnt), 64'h0);
    check("rst_valid", 64'(y_valid), 64'h0);
    check("rst_ack", 64'(ack), 64'h0);
    model_reset();
    req      = 4'b0000;
    y_ready  = 1'b0;
    lock_drv = 4'b0000;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (run_mon && !rst) begin
      if (timeout) to_seen++;
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("present", 64'({y_valid, timeout}), 64'({mon_e.valid, mon_e.to}));
        check("gnt", 64'(gnt), 64'(mon_e.gnt));
        check("ack", 64'(ack), 64'(mon_e.ack));
        if (mon_e.valid) begin
          check("s", 64'(s), 64'(mon_e.s));
          check("y", 64'(y), 64'(mon_e.y));
        end
      end else if (y_valid || timeout) begin
        check("unexpected", 64'({y_valid, timeout}), 64'h0);
      end else begin
        check("idle_out", 64'({gnt, ack}), 64'h0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [3:0] r;
    logic [3:0] lk;
    logic       rdy;
    int         to_before;

    rst      = 1'b1;
    req      = 4'b0000;
    y_ready  = 1'b0;
    lock_drv = 4'b0000;
    for (int i = 0; i < 4; i++) a_drv[i] = $urandom;
    edge_n = 0;
    model_reset();
    #12;
    check("reset_gnt", 64'(gnt), 64'h0);
    check("reset_s", 64'(s), 64'h0);
    check("reset_valid", 64'(y_valid), 64'h0);
    check("reset_ack", 64'(ack), 64'h0);
    check("reset_timeout", 64'(timeout), 64'h0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    run_mon = 1'b1;

    // Single request with known data.
    a_drv[0] = 32'hDEADBEEF;
    step(4'b0001, 1'b1, 4'b0000);
    step(4'b0001, 1'b1, 4'b0000);
    repeat (3) step(4'b0000, 1'b0, 4'b0000);

    // Round robin with everyone requesting.
    do_reset();
    repeat (12) step(4'b1111, 1'b1, 4'b0000);
    repeat (2) step(4'b0000, 1'b0, 4'b0000);

    // Backpressure until timeout, then requester 3 is next.
    do_reset();
    to_before = to_seen;
    repeat (16) step(4'b0100, 1'b0, 4'b0000);
    step(4'b1100, 1'b0, 4'b0000);
    repeat (4) step(4'b1100, 1'b1, 4'b0000);
    repeat (2) step(4'b0000, 1'b0, 4'b0000);
    check("timeout_pulses", 64'(to_seen - to_before), 64'd1);

    // Withdrawal aborts; ptr stays so requester 0 still wins next.
    do_reset();
    repeat (4) step(4'b0010, 1'b0, 4'b0000);
    step(4'b0000, 1'b0, 4'b0000);
    repeat (3) step(4'b1111, 1'b1, 4'b0000);
    // Request falling together with ready still counts as a handshake.
    step(4'b0100, 1'b0, 4'b0000);
    repeat (2) step(4'b0100, 1'b0, 4'b0000);
    step(4'b0000, 1'b1, 4'b0000);
    repeat (2) step(4'b0000, 1'b0, 4'b0000);

    // Asynchronous reset while a grant is active.
    do_reset();
    repeat (3) step(4'b0001, 1'b0, 4'b0000);
    do_reset();
    repeat (3) step(4'b1111, 1'b1, 4'b0000);
    repeat (2) step(4'b0000, 1'b0, 4'b0000);

`ifdef ARB4X32_LOCK_EN
    do_reset();
    repeat (6) step(4'b0011, 1'b1, 4'b0010);
    repeat (4) step(4'b0011, 1'b1, 4'b0000);
    repeat (2) step(4'b0000, 1'b0, 4'b0000);
`endif

    // Random traffic with periodic stall windows long enough to expire the hold.
    do_reset();
    r  = 4'b0000;
    lk = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (r[i]) begin
          if ($urandom_range(0, 15) == 0) r[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          r[i] = 1'b1;
        end
      end
      rdy = ((c % 150) >= 125) ? 1'b0 : ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) lk = 4'($urandom);
      step(r, rdy, lk);
    end
    repeat (3) step(4'b0000, 1'b1, 4'b0000);
    @(posedge clk);
    #1;
    check("sb_drain", 64'(sb.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
